// File: rtl/max_scan_pkg.sv
// Shared definitions for the max_scan reduction engine: FSM encoding,
// comparator width and the index-width legality check.
package max_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The comparator is hard-wired to this width; DATA_W must match it.
  localparam int MAG_W          = 4;
  localparam int DATA_W_DEFAULT = MAG_W;
  localparam int IDX_W_DEFAULT  = 6;

  function automatic bit idx_w_ok(input int w);
    return (w >= 1) && (w <= 30);
  endfunction

endpackage

// File: rtl/mag_gt.sv
// Unsigned strict greater-than (gt = a > b), resolved MSB-first from
// per-bit greater and equal terms.
module mag_gt
  import max_scan_pkg::*;
(
  input  logic [MAG_W-1:0] a,
  input  logic [MAG_W-1:0] b,
  output logic             gt
);

  logic [MAG_W-1:0] bit_gt;
  logic [MAG_W-1:0] bit_eq;
  logic [MAG_W-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < MAG_W; gi++) begin : g_bit
      // Bits strictly above gi must all be equal for bit gi to decide.
      localparam logic [MAG_W-1:0] ABOVE = MAG_W'(~((1 << (gi + 1)) - 1));

      assign bit_gt[gi] = a[gi] & ~b[gi];
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]);
      assign hit[gi]    = bit_gt[gi] & (&(bit_eq | ~ABOVE));
    end
  endgenerate

  assign gt = |hit;

endmodule

// File: rtl/max_scan_ctrl.sv
// Frame max-scan controller: finds the maximum of a valid/ready frame and the
// index of its first occurrence. Define MAX_SCAN_MIN_EN to also track the minimum.
module max_scan_ctrl
  import max_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W-1:0]  out_count,
`ifdef MAX_SCAN_MIN_EN
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_min_idx,
`endif
  output logic              out_ovf
);

  generate
    if (DATA_W != MAG_W) begin : g_bad_data_w
      $error("max_scan_ctrl: DATA_W must equal the comparator width");
    end
    if (!idx_w_ok(IDX_W)) begin : g_bad_idx_w
      $error("max_scan_ctrl: IDX_W out of range");
    end
  endgenerate

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] max_reg, max_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic              xfer;
  logic              max_gt;
  logic [IDX_W-1:0]  upd_idx;

  mag_gt u_max_gt (
    .a  (in_data),
    .b  (max_reg),
    .gt (max_gt)
  );

`ifdef MAX_SCAN_MIN_EN
  logic [DATA_W-1:0] min_reg, min_next;
  logic [IDX_W-1:0]  min_idx_reg, min_idx_next;
  logic              min_gt;

  mag_gt u_min_gt (
    .a  (min_reg),
    .b  (in_data),
    .gt (min_gt)
  );
`endif

  assign in_ready = (state_reg != S_DONE);
  assign xfer     = in_valid & in_ready;
  // Once the count saturates, new extremes report the saturated index.
  assign upd_idx  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    max_next   = max_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
`ifdef MAX_SCAN_MIN_EN
    min_next     = min_reg;
    min_idx_next = min_idx_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (xfer) begin
          max_next   = in_data;
          idx_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
`ifdef MAX_SCAN_MIN_EN
          min_next     = in_data;
          min_idx_next = '0;
`endif
          state_next = in_last ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (xfer) begin
          if (cnt_reg == CNT_MAX) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
          if (max_gt) begin
            max_next = in_data;
            idx_next = upd_idx;
          end
`ifdef MAX_SCAN_MIN_EN
          if (min_gt) begin
            min_next     = in_data;
            min_idx_next = upd_idx;
          end
`endif
          if (in_last) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Reset and clear have the same effect; either one drops any beat this cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_reg <= S_IDLE;
      max_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
`ifdef MAX_SCAN_MIN_EN
      min_reg     <= '0;
      min_idx_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      max_reg   <= max_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
`ifdef MAX_SCAN_MIN_EN
      min_reg     <= min_next;
      min_idx_reg <= min_idx_next;
`endif
    end
  end

  assign out_valid = (state_reg == S_DONE);
  assign out_max   = max_reg;
  assign out_idx   = idx_reg;
  assign out_count = cnt_reg;
  assign out_ovf   = ovf_reg;
`ifdef MAX_SCAN_MIN_EN
  assign out_min     = min_reg;
  assign out_min_idx = min_idx_reg;
`endif

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Directed self-checking bench for max_scan_ctrl; honours MAX_SCAN_MIN_EN.
module tb_max_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, in_last, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [3:0] out_max;
  logic [5:0] out_idx, out_count;
`ifdef MAX_SCAN_MIN_EN
  logic [3:0] out_min;
  logic [5:0] out_min_idx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_count (out_count),
`ifdef MAX_SCAN_MIN_EN
    .out_min     (out_min),
    .out_min_idx (out_min_idx),
`endif
    .out_ovf   (out_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 4'h0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_max", out_max, 0);
    check("rst_idx", out_idx, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    $display("reset released");

    // Frame 3,9,2,9,5: earliest 9 wins
    out_ready = 1'b1;
    send(4'h3, 0); send(4'h9, 0); send(4'h2, 0); send(4'h9, 0);
    check("f1_not_yet_valid", out_valid, 0);
    send(4'h5, 1);
    check("f1_valid", out_valid, 1);
    check("f1_max", out_max, 9);
    check("f1_idx", out_idx, 1);
    check("f1_count", out_count, 4);
    check("f1_ovf", out_ovf, 0);
    check("f1_ready_low", in_ready, 0);
    step();
    check("f1_valid_one_cycle", out_valid, 0);
    $display("frame 1 max=%0d idx=%0d", 9, 1);

    // Single beat F held by back-pressure; a pending beat must not sneak in
    out_ready = 1'b0;
    send(4'hF, 1);
    in_valid = 1'b1; in_data = 4'h3; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("f2_hold_valid", out_valid, 1);
      check("f2_hold_max", out_max, 4'hF);
      check("f2_hold_idx", out_idx, 0);
      check("f2_hold_count", out_count, 0);
      check("f2_hold_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("f2_released_valid", out_valid, 0);
    check("f2_released_ready", in_ready, 1);
    step();
    check("f2_no_frame_in_handshake", out_valid, 0);
    $display("frame 2 single beat held 5 cycles");

    // All-zero frame of 8 beats
    for (int i = 0; i < 8; i++) send(4'h0, i == 7);
    check("f3_valid", out_valid, 1);
    check("f3_max", out_max, 0);
    check("f3_idx", out_idx, 0);
    check("f3_count", out_count, 7);
`ifdef MAX_SCAN_MIN_EN
    check("f3_min", out_min, 0);
    check("f3_min_idx", out_min_idx, 0);
`endif
    step();
    $display("frame 3 all zero");

    // Ascending frame: maximum at the end, minimum at the start
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 1);
    check("f4_max", out_max, 4);
    check("f4_idx", out_idx, 3);
    check("f4_count", out_count, 3);
`ifdef MAX_SCAN_MIN_EN
    check("f4_min", out_min, 1);
    check("f4_min_idx", out_min_idx, 0);
`endif
    step();
    $display("frame 4 ascending");

    // 65 beats overflow the 6-bit count
    for (int i = 0; i < 65; i++) send((i == 64) ? 4'h1 : 4'h0, i == 64);
    check("f5_valid", out_valid, 1);
    check("f5_ovf", out_ovf, 1);
    check("f5_count", out_count, 63);
    check("f5_max", out_max, 1);
    step();
    $display("frame 5 overflow");

    // clear on the third beat drops it and the frame
    send(4'h7, 0); send(4'h8, 0);
    clear = 1'b1;
    send(4'hC, 0);
    clear = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_ready", in_ready, 1);
    check("clr_max_zeroed", out_max, 0);
    check("clr_count_zeroed", out_count, 0);
    send(4'h2, 0); send(4'h6, 1);
    check("f6_valid", out_valid, 1);
    check("f6_max", out_max, 6);
    check("f6_idx", out_idx, 1);
    check("f6_count", out_count, 1);
    check("f6_ovf", out_ovf, 0);
    step();
    $display("frame 6 after clear");

    // reset while in DONE
    out_ready = 1'b0;
    send(4'hA, 1);
    check("f7_valid", out_valid, 1);
    check("f7_max", out_max, 4'hA);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_valid", out_valid, 0);
    check("rst2_ready", in_ready, 1);
    check("rst2_max", out_max, 0);
    check("rst2_idx", out_idx, 0);
    check("rst2_count", out_count, 0);
    check("rst2_ovf", out_ovf, 0);
    $display("reset during DONE");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
